// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser on serialOut.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             ovf_clr,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             busy,
  output logic             tx_done,
  output logic             serialOut
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CntFull  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             push, pop, drop;
  logic [7:0]       head;

  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             baud_last;
  logic             done;
  logic             line_d, serial_q, done_q;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign full      = (count_q == CntFull);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != StIdle);
  assign tx_done   = done_q;
  assign serialOut = serial_q;

  // Full/empty come from the pre-edge count, so a pop cannot make room for a same-edge write.
  assign push      = wr_en & ~full;
  assign drop      = wr_en & full;
  assign head      = mem_q[rd_ptr_q];
  assign baud_last = (baud_q == BaudLast);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StStart;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`endif
      StStop: begin
        if (baud_last) begin
          done   = 1'b1;
          baud_d = '0;
          // Chain straight into the next start bit when more bytes are waiting.
          if (!empty) begin
            pop     = 1'b1;
            state_d = StStart;
            bit_d   = '0;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    line_d = 1'b1;
    unique case (state_q)
      StStart:  line_d = 1'b0;
      StData:   line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      StParity: line_d = parity_q;
`endif
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= line_d;
      done_q   <= done;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frame table, corner sequences and random traffic
// compared every cycle against a queue-based frame-timing model.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          ovf_clr;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          busy;
  logic          tx_done;
  logic          serialOut;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .ovf_clr  (ovf_clr),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .tx_done  (tx_done),
    .serialOut(serialOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int done_seen = 0;
  int cnt_peak = 0;

  // Reference model: a byte queue plus the age (in clock edges) of the frame being sent.
  logic [7:0] m_q[$];
  bit         m_ovf = 1'b0;
  bit         m_in_frame = 1'b0;
  bit         m_done = 1'b0;
  int         m_age = 0;
  logic [7:0] m_byte = 8'h00;

  function automatic bit frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic bit exp_line();
    if (!m_in_frame || m_age == 0) return 1'b1;
    return frame_bit(m_byte, (m_age - 1) / CPB);
  endfunction

  task automatic model_edge(input bit we, input logic [7:0] wd, input bit clr, input bit rst);
    int n;
    bit do_pop;
    if (rst) begin
      m_q.delete();
      m_ovf      = 1'b0;
      m_in_frame = 1'b0;
      m_done     = 1'b0;
      m_age      = 0;
    end else begin
      n      = m_q.size();
      do_pop = 1'b0;
      m_done = 1'b0;
      if (m_in_frame) begin
        m_age++;
        if (m_age == FRAME_BITS * CPB) begin
          m_done     = 1'b1;
          m_in_frame = 1'b0;
          do_pop     = (n > 0);
        end
      end else begin
        do_pop = (n > 0);
      end
      if (we && n < DEPTH) m_q.push_back(wd);
      if (we && n == DEPTH) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (do_pop) begin
        m_byte     = m_q.pop_front();
        m_in_frame = 1'b1;
        m_age      = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("serialOut", 32'(serialOut), 32'(exp_line()));
    chk("busy",      32'(busy),      32'(m_in_frame));
    chk("tx_done",   32'(tx_done),   32'(m_done));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("count",     32'(count),     32'(m_q.size()));
    chk("empty",     32'(empty),     32'(m_q.size() == 0));
    chk("full",      32'(full),      32'(m_q.size() == DEPTH));
    if (tx_done === 1'b1) done_seen++;
    if (int'(count) > cnt_peak) cnt_peak = int'(count);
  endtask

  // Drive inputs for one edge (called just after a falling edge), then sample at the next fall.
  task automatic tick(input bit we, input logic [7:0] wd, input bit clr, input bit rst);
    wr_en   = we;
    wr_data = wd;
    ovf_clr = clr;
    reset   = rst;
    model_edge(we, wd, clr, rst);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  typedef struct packed {
    logic [7:0] c;
    logic       line;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int c;
    int d0;
    int rate;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    reset   = 1'b1;
    @(negedge clk);

    // Reset, then a quiet line.
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("reset_serial", 32'(serialOut), 32'd1);
    chk("reset_empty", 32'(empty), 32'd1);
    idle(20);

`ifndef UART_TX_PARITY_EN
    // 0xA5 frame: c counts edges since the write edge; the start bit appears at c=2.
    tbl = '{
      '{8'd0,  1'b1, 1'b0, 1'b0}, '{8'd1,  1'b1, 1'b0, 1'b1},
      '{8'd2,  1'b0, 1'b0, 1'b1}, '{8'd5,  1'b0, 1'b0, 1'b1},
      '{8'd6,  1'b1, 1'b0, 1'b1}, '{8'd10, 1'b0, 1'b0, 1'b1},
      '{8'd14, 1'b1, 1'b0, 1'b1}, '{8'd18, 1'b0, 1'b0, 1'b1},
      '{8'd22, 1'b0, 1'b0, 1'b1}, '{8'd26, 1'b1, 1'b0, 1'b1},
      '{8'd30, 1'b0, 1'b0, 1'b1}, '{8'd34, 1'b1, 1'b0, 1'b1},
      '{8'd38, 1'b1, 1'b0, 1'b1}, '{8'd40, 1'b1, 1'b0, 1'b1},
      '{8'd41, 1'b1, 1'b1, 1'b0}, '{8'd42, 1'b1, 1'b0, 1'b0}
    };
    c = 0;
    tick(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      while (c < int'(tbl[i].c)) begin
        idle(1);
        c++;
      end
      chk("tbl_line", 32'(serialOut), 32'(tbl[i].line));
      chk("tbl_done", 32'(tx_done),   32'(tbl[i].done));
      chk("tbl_busy", 32'(busy),      32'(tbl[i].busy));
    end
`else
    tick(1'b1, 8'h07, 1'b0, 1'b0);
    idle(50);
    tick(1'b1, 8'h03, 1'b0, 1'b0);
    idle(50);
`endif
    idle(5);

    // Three back-to-back frames.
    d0 = done_seen;
    cnt_peak = 0;
    tick(1'b1, 8'h01, 1'b0, 1'b0);
    tick(1'b1, 8'h02, 1'b0, 1'b0);
    tick(1'b1, 8'h03, 1'b0, 1'b0);
    idle(3 * FRAME_BITS * CPB + 10);
    chk("b2b_peak", 32'(cnt_peak), 32'd2);
    chk("b2b_done", 32'(done_seen - d0), 32'd3);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Fill while a frame is in flight, drop the overflow byte, then clear the flag.
    d0 = done_seen;
    tick(1'b1, 8'h10, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ovf", 32'(overflow), 32'd1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_clr", 32'(overflow), 32'd0);
    tick(1'b1, 8'h77, 1'b1, 1'b0);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    idle(5 * FRAME_BITS * CPB + 10);
    chk("fill_frames", 32'(done_seen - d0), 32'd5);

    // Reset in the middle of a data bit discards the frame and the queue.
    tick(1'b1, 8'h11, 1'b0, 1'b0);
    tick(1'b1, 8'h22, 1'b0, 1'b0);
    idle(15);
    d0 = done_seen;
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("abort_line", 32'(serialOut), 32'd1);
    chk("abort_empty", 32'(empty), 32'd1);
    idle(10);
    tick(1'b1, 8'h3C, 1'b0, 1'b0);
    idle(FRAME_BITS * CPB + 5);
    chk("abort_done", 32'(done_seen - d0), 32'd1);

    // Random traffic with alternating light and heavy write rates.
    for (int i = 0; i < 3000; i++) begin
      rate = ((i / 500) % 2 == 0) ? 3 : 30;
      tick(($urandom_range(0, 99) < rate), 8'($urandom), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 1499) == 0));
    end
    idle(DEPTH * FRAME_BITS * CPB + FRAME_BITS * CPB + 10);
    chk("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
